// File: rtl/mmio_ctrl_ws.sv
// MMIO controller with per-slot ready handshake, wait states and timeout.
// Decodes the slot field, strobes the slot for one cycle and waits for its ready.
module mmio_ctrl_ws #(
  parameter int                 N_SLOTS   = 64,
  parameter int                 REG_W     = 5,
  parameter int                 ADDR_W    = 21,
  parameter logic [N_SLOTS-1:0] SLOT_MASK = '1,
  parameter int                 TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mmio_cs,
  input  logic                    mmio_rd,
  input  logic                    mmio_wr,
  input  logic [ADDR_W-1:0]       mmio_addr,
  input  logic [31:0]             mmio_wr_data,
  output logic [31:0]             mmio_rd_data,
  output logic                    mmio_ready,
  output logic                    mmio_err,
  output logic                    mmio_busy,
  output logic [N_SLOTS-1:0]      io_cs,
  output logic                    io_rd,
  output logic                    io_wr,
  output logic [REG_W-1:0]        io_reg_addr,
  output logic [31:0]             io_wr_data,
  input  logic [32*N_SLOTS-1:0]   io_rd_data,
  input  logic [N_SLOTS-1:0]      io_ready
);

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, ACCESS, WAIT, RESP, ERR
  } state_t;

  state_t              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic                rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         rd_data_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;
  logic [N_SLOTS-1:0]  cs_q;
  logic                io_rd_q;
  logic                io_wr_q;
  logic [REG_W-1:0]    reg_q;
  logic [31:0]         wdata_q;

  logic                req;
  logic                both;
  logic [SLOT_W-1:0]   slot_d;
  logic                mapped;
  logic [N_SLOTS-1:0]  cs_d;
  logic                sel_rdy;
  logic [31:0]         sel_data;
  logic                to_hit;

  assign req      = mmio_cs & (mmio_rd ^ mmio_wr);
  assign both     = mmio_cs & mmio_rd & mmio_wr;
  assign slot_d   = mmio_addr[REG_W+SLOT_W-1:REG_W];
  assign mapped   = ({1'b0, slot_d} < (SLOT_W+1)'(N_SLOTS))
                    && SLOT_MASK[slot_d];
  assign cs_d     = N_SLOTS'(1) << slot_d;
  assign sel_rdy  = io_ready[slot_q];
  assign sel_data = io_rd_data[{slot_q, 5'b00000} +: 32];
  // Ready arriving on the timeout cycle wins over the error.
  assign to_hit   = (TIMEOUT != 0)
                    && ((cnt_q + 1'b1) == CNT_W'(TIMEOUT));

  generate
    if (ADDR_W > REG_W + SLOT_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^mmio_addr[ADDR_W-1:REG_W+SLOT_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= '0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      reg_q     <= '0;
      wdata_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      io_rd_q <= 1'b0;
      io_wr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (both) begin
            state_q   <= ERR;
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            rd_data_q <= 32'hFFFF_FFFF;
          end else if (req) begin
            slot_q  <= slot_d;
            rd_q    <= mmio_rd;
            reg_q   <= mmio_addr[REG_W-1:0];
            wdata_q <= mmio_wr_data;
            if (mapped) begin
              state_q <= ACCESS;
              busy_q  <= 1'b1;
              cs_q    <= cs_d;
              io_rd_q <= mmio_rd;
              io_wr_q <= mmio_wr;
            end else begin
              state_q <= ERR;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              if (mmio_rd) rd_data_q <= 32'hFFFF_FFFF;
            end
          end
        end
        ACCESS, WAIT: begin
          if (sel_rdy) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cs_q    <= '0;
            if (rd_q) rd_data_q <= sel_data;
          end else if (state_q == WAIT && to_hit) begin
            state_q <= ERR;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            cs_q    <= '0;
            if (rd_q) rd_data_q <= 32'hFFFF_FFFF;
          end else begin
            state_q <= WAIT;
            cnt_q   <= (state_q == ACCESS) ? '0 : cnt_q + 1'b1;
          end
        end
        RESP, ERR: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign mmio_rd_data = rd_data_q;
  assign mmio_ready   = ready_q;
  assign mmio_err     = err_q;
  assign mmio_busy    = busy_q;
  assign io_cs        = cs_q;
  assign io_rd        = io_rd_q;
  assign io_wr        = io_wr_q;
  assign io_reg_addr  = reg_q;
  assign io_wr_data   = wdata_q;

endmodule

// File: tb/tb_mmio_ctrl_ws.sv
// Directed bench for mmio_ctrl_ws: latency, wait states, errors, reset.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_mmio_ctrl_ws;

  localparam int NS = 64;
  localparam int RW = 5;
  localparam int AW = 21;
  localparam logic [NS-1:0] MASK = 64'hFFFF_FFFF_FFEF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            mmio_cs, mmio_rd, mmio_wr;
  logic [AW-1:0]   mmio_addr;
  logic [31:0]     mmio_wr_data;
  logic [31:0]     mmio_rd_data;
  logic            mmio_ready, mmio_err, mmio_busy;
  logic [NS-1:0]   io_cs;
  logic            io_rd, io_wr;
  logic [RW-1:0]   io_reg_addr;
  logic [31:0]     io_wr_data;
  logic [32*NS-1:0] io_rd_data;
  logic [NS-1:0]   io_ready;

  int pass_cnt = 0;
  int total = 0;

  mmio_ctrl_ws #(
    .N_SLOTS(NS), .REG_W(RW), .ADDR_W(AW),
    .SLOT_MASK(MASK), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .mmio_cs(mmio_cs), .mmio_rd(mmio_rd), .mmio_wr(mmio_wr),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
    .mmio_err(mmio_err), .mmio_busy(mmio_busy),
    .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
    .io_reg_addr(io_reg_addr), .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input int slot, input int ra,
                       input logic [31:0] wd);
    mmio_cs      = 1'b1;
    mmio_rd      = rd;
    mmio_wr      = wr;
    mmio_addr    = AW'((slot << RW) | ra);
    mmio_wr_data = wd;
  endtask

  task automatic idle_bus();
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    mmio_wr = 1'b0;
  endtask

  // Issue one request and return the cycle of mmio_ready (-1 if none).
  task automatic run(input logic rd, input logic wr,
                     input int slot, input int ra,
                     input logic [31:0] wd,
                     input int rs, input int rc,
                     output int rcyc, output logic rerr,
                     output int cs_cyc, output int strb);
    drive(rd, wr, slot, ra, wd);
    rcyc = -1; rerr = 1'bx; cs_cyc = 0; strb = 0;
    step();
    idle_bus();
    for (int c = 1; c <= 40; c++) begin
      if (c == rc) io_ready[rs] = 1'b1;
      if (io_cs != '0) cs_cyc++;
      if (io_rd | io_wr) strb++;
      if (mmio_ready) begin
        rcyc = c;
        rerr = mmio_err;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_bus();
    mmio_addr = '0;
    mmio_wr_data = '0;
    step(); step();
    total++; if (mmio_rd_data !== 32'h0) $display("FAIL rst_rdata got %h want 0", mmio_rd_data); else pass_cnt++;
    total++; if ({mmio_ready, mmio_err, mmio_busy} !== 3'b000) $display("FAIL rst_flags got %b want 000", {mmio_ready, mmio_err, mmio_busy}); else pass_cnt++;
    total++; if (io_cs !== '0) $display("FAIL rst_cs got %h want 0", io_cs); else pass_cnt++;
    total++; if ({io_rd, io_wr, io_reg_addr} !== '0) $display("FAIL rst_strobe got %b want 0", {io_rd, io_wr, io_reg_addr}); else pass_cnt++;
    total++; if (io_wr_data !== 32'h0) $display("FAIL rst_wdata got %h want 0", io_wr_data); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_legacy_read();
    drive(1'b1, 1'b0, 3, 0, 32'h0);
    step();
    idle_bus();
    total++; if (io_cs !== (64'd1 << 3)) $display("FAIL leg_cs got %h want %h", io_cs, 64'd1 << 3); else pass_cnt++;
    total++; if ({io_rd, io_wr, mmio_busy, mmio_ready} !== 4'b1010) $display("FAIL leg_strb got %b want 1010", {io_rd, io_wr, mmio_busy, mmio_ready}); else pass_cnt++;
    step();
    total++; if ({mmio_ready, mmio_err} !== 2'b10) $display("FAIL leg_rdy got %b want 10", {mmio_ready, mmio_err}); else pass_cnt++;
    total++; if (mmio_rd_data !== 32'h0000_000A) $display("FAIL leg_data got %h want 0000000a", mmio_rd_data); else pass_cnt++;
    total++; if ({io_cs != '0, io_rd} !== 2'b00) $display("FAIL leg_release got %b want 00", {io_cs != '0, io_rd}); else pass_cnt++;
    step();
    total++; if (mmio_ready !== 1'b0) $display("FAIL leg_pulse got %b want 0", mmio_ready); else pass_cnt++;
  endtask

  task automatic test_wait_write();
    int rcyc, strb;
    logic rerr;
    logic saw_hold;
    io_ready[6] = 1'b0;
    drive(1'b0, 1'b1, 6, 2, 32'h1234_5678);
    step();
    idle_bus();
    total++; if ({io_wr, io_reg_addr} !== {1'b1, 5'd2}) $display("FAIL ws_strobe got %b want 100010", {io_wr, io_reg_addr}); else pass_cnt++;
    total++; if (io_wr_data !== 32'h1234_5678) $display("FAIL ws_wdata got %h want 12345678", io_wr_data); else pass_cnt++;
    rcyc = -1; rerr = 1'bx; strb = 0; saw_hold = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) io_ready[6] = 1'b1;
      if (io_wr) strb++;
      if (c == 3 && io_cs == (64'd1 << 6) && !io_wr && mmio_busy) saw_hold = 1'b1;
      if (mmio_ready) begin rcyc = c; rerr = mmio_err; break; end
      step();
    end
    total++; if (rcyc !== 6) $display("FAIL ws_latency got %0d want 6", rcyc); else pass_cnt++;
    total++; if (strb !== 1) $display("FAIL ws_pulses got %0d want 1", strb); else pass_cnt++;
    total++; if (saw_hold !== 1'b1) $display("FAIL ws_cs_hold got %b want 1", saw_hold); else pass_cnt++;
    total++; if ({rerr, mmio_rd_data} !== {1'b0, 32'h0000_000A}) $display("FAIL ws_rdata got %h want 0000000a err0", {rerr, mmio_rd_data}); else pass_cnt++;
    step();
  endtask

  task automatic test_unmapped();
    int rcyc, cs_cyc, strb;
    logic rerr;
    run(1'b1, 1'b0, 20, 1, 32'h0, 0, 0, rcyc, rerr, cs_cyc, strb);
    total++; if (rcyc !== 1) $display("FAIL unm_latency got %0d want 1", rcyc); else pass_cnt++;
    total++; if ({rerr, cs_cyc != 0} !== 2'b10) $display("FAIL unm_err got %b want 10", {rerr, cs_cyc != 0}); else pass_cnt++;
    total++; if (mmio_rd_data !== 32'hFFFF_FFFF) $display("FAIL unm_data got %h want ffffffff", mmio_rd_data); else pass_cnt++;
    step();
  endtask

  task automatic test_timeout();
    int rcyc, cs_cyc, strb;
    logic rerr;
    io_ready[12] = 1'b0;
    run(1'b1, 1'b0, 12, 0, 32'h0, 0, 0, rcyc, rerr, cs_cyc, strb);
    total++; if (rcyc !== 18) $display("FAIL to_latency got %0d want 18", rcyc); else pass_cnt++;
    total++; if (rerr !== 1'b1) $display("FAIL to_err got %b want 1", rerr); else pass_cnt++;
    total++; if (mmio_rd_data !== 32'hFFFF_FFFF) $display("FAIL to_data got %h want ffffffff", mmio_rd_data); else pass_cnt++;
    total++; if (strb !== 1) $display("FAIL to_strobe got %0d want 1", strb); else pass_cnt++;
    step();
    total++; if ({mmio_ready, mmio_busy, io_cs != '0} !== 3'b000) $display("FAIL to_idle got %b want 000", {mmio_ready, mmio_busy, io_cs != '0}); else pass_cnt++;
  endtask

  task automatic test_both();
    int rcyc, cs_cyc, strb;
    logic rerr;
    run(1'b1, 1'b1, 3, 0, 32'h0, 0, 0, rcyc, rerr, cs_cyc, strb);
    total++; if (rcyc !== 1) $display("FAIL both_latency got %0d want 1", rcyc); else pass_cnt++;
    total++; if ({rerr, cs_cyc != 0, strb != 0} !== 3'b100) $display("FAIL both_err got %b want 100", {rerr, cs_cyc != 0, strb != 0}); else pass_cnt++;
    step();
  endtask

  task automatic test_busy_ignore();
    int comps, first;
    logic saw3, busy2;
    io_ready[6] = 1'b0;
    drive(1'b1, 1'b0, 6, 0, 32'h0);
    step();
    idle_bus();
    comps = 0; first = -1; saw3 = 1'b0; busy2 = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 2) begin
        busy2 = mmio_busy;
        drive(1'b1, 1'b0, 3, 0, 32'h0);
      end
      if (c == 3) begin
        idle_bus();
        io_ready[6] = 1'b1;
      end
      if (io_cs[3]) saw3 = 1'b1;
      if (mmio_ready) begin
        comps++;
        if (first < 0) first = c;
      end
      if (c == first) begin
        total++; if (mmio_rd_data !== 32'h6666_0006) $display("FAIL busy_data got %h want 66660006", mmio_rd_data); else pass_cnt++;
      end
      step();
    end
    total++; if (busy2 !== 1'b1) $display("FAIL busy_flag got %b want 1", busy2); else pass_cnt++;
    total++; if (comps !== 1) $display("FAIL busy_comps got %0d want 1", comps); else pass_cnt++;
    total++; if (first !== 4) $display("FAIL busy_latency got %0d want 4", first); else pass_cnt++;
    total++; if (saw3 !== 1'b0) $display("FAIL busy_ignored got %b want 0", saw3); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int rcyc, cs_cyc, strb;
    logic rerr;
    run(1'b0, 1'b1, 5, 7, 32'hCAFE_0005, 0, 0, rcyc, rerr, cs_cyc, strb);
    total++; if ({rcyc, rerr} !== {32'd2, 1'b0}) $display("FAIL b2b_first got %0d/%b want 2/0", rcyc, rerr); else pass_cnt++;
    step();
    run(1'b1, 1'b0, 7, 1, 32'h0, 0, 0, rcyc, rerr, cs_cyc, strb);
    total++; if ({rcyc, rerr} !== {32'd2, 1'b0}) $display("FAIL b2b_second got %0d/%b want 2/0", rcyc, rerr); else pass_cnt++;
    total++; if (mmio_rd_data !== 32'h7777_0007) $display("FAIL b2b_data got %h want 77770007", mmio_rd_data); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int comps, rcyc, cs_cyc, strb;
    logic rerr;
    io_ready[12] = 1'b0;
    drive(1'b1, 1'b0, 12, 0, 32'h0);
    step();
    idle_bus();
    step(); step(); step();
    #2 rst = 1'b0;
    #1;
    total++; if ({mmio_ready, mmio_err, mmio_busy, io_rd, io_wr} !== 5'b0) $display("FAIL rmw_flags got %b want 0", {mmio_ready, mmio_err, mmio_busy, io_rd, io_wr}); else pass_cnt++;
    total++; if ({io_cs, mmio_rd_data} !== '0) $display("FAIL rmw_cs_data got %h/%h want 0", io_cs, mmio_rd_data); else pass_cnt++;
    comps = 0;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      if (mmio_ready) comps++;
      step();
    end
    total++; if (comps !== 0) $display("FAIL rmw_nopulse got %0d want 0", comps); else pass_cnt++;
    io_ready[12] = 1'b1;
    run(1'b1, 1'b0, 12, 0, 32'h0, 0, 0, rcyc, rerr, cs_cyc, strb);
    total++; if ({rcyc, rerr} !== {32'd2, 1'b0}) $display("FAIL rmw_after got %0d/%b want 2/0", rcyc, rerr); else pass_cnt++;
    total++; if (mmio_rd_data !== 32'hC0C0_000C) $display("FAIL rmw_data got %h want c0c0000c", mmio_rd_data); else pass_cnt++;
    step();
  endtask

  initial begin
    io_ready = '1;
    io_rd_data = '0;
    io_rd_data[3*32 +: 32]  = 32'h0000_000A;
    io_rd_data[6*32 +: 32]  = 32'h6666_0006;
    io_rd_data[7*32 +: 32]  = 32'h7777_0007;
    io_rd_data[12*32 +: 32] = 32'hC0C0_000C;
    test_reset();
    test_legacy_read();
    test_wait_write();
    test_unmapped();
    test_timeout();
    test_both();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
